// File: rtl/ps2_init_sequencer.sv
// Power-up sequencer for a PS/2 device: inhibit, reset (0xFF), ACK/BAT check, enable (0xF4),
// then forwards clean received bytes; errors, timeouts and resend requests cost retry budget.

package ps2_pkg;
    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic timeout_err;
    } flags_t;
endpackage

module ps2_init_sequencer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 150,
    parameter int RESP_TO_MS = 25,
    parameter int BAT_TO_MS  = 1000,
    parameter int MAX_RETRY  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             en,
    output logic             tx_rqst,
    output logic [7:0]       tx_data,
    input  logic             valid,
    input  logic [7:0]       rx_data,
    input  ps2_pkg::flags_t  flags,
    output logic             ready,
    output logic             fail,
    output logic [7:0]       code,
    output logic             code_valid,
    output logic             rx_err
);

    localparam longint INHIBIT_RAW = longint'(INHIBIT_US) * longint'(CLK_HZ) / 1_000_000;
    localparam longint RESP_RAW    = longint'(RESP_TO_MS) * longint'(CLK_HZ) / 1_000;
    localparam longint BAT_RAW     = longint'(BAT_TO_MS)  * longint'(CLK_HZ) / 1_000;

    localparam longint INHIBIT_CYC = (INHIBIT_RAW < 1) ? 1 : INHIBIT_RAW;
    localparam longint RESP_CYC    = (RESP_RAW    < 1) ? 1 : RESP_RAW;
    localparam longint BAT_CYC     = (BAT_RAW     < 1) ? 1 : BAT_RAW;

    localparam longint MAX_CYC = (INHIBIT_CYC > RESP_CYC)
                               ? ((INHIBIT_CYC > BAT_CYC) ? INHIBIT_CYC : BAT_CYC)
                               : ((RESP_CYC    > BAT_CYC) ? RESP_CYC    : BAT_CYC);

    localparam int TW = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // Terminal counts: the timer starts at 0 on state entry, so N cycles end at N-1.
    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] RESP_LAST    = TW'(RESP_CYC - 1);
    localparam logic [TW-1:0] BAT_LAST     = TW'(BAT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_BAT_KO = 8'hFC;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_WAIT_BAT,
        S_RETRY,
        S_READY,
        S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            en_q, en_d;
    logic            tx_rqst_q, tx_rqst_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            ready_q, ready_d;
    logic            fail_q, fail_d;
    logic [7:0]      code_q, code_d;
    logic            code_valid_q, code_valid_d;
    logic            rx_err_q, rx_err_d;

    logic rx_ok;
    logic rx_bad;

    assign rx_ok  = valid && !(|flags);
    assign rx_bad = valid && (|flags);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d      = state_q;
        cmd_d        = cmd_q;
        retry_d      = retry_q;
        tx_rqst_d    = 1'b0;
        tx_data_d    = tx_data_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        rx_err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INHIBIT;
                    retry_d = '0;
                end
            end

            S_INHIBIT: begin
                if (timer_q >= INHIBIT_LAST) begin
                    state_d = S_SEND;
                    cmd_d   = CMD_RESET;
                end
            end

            S_SEND: begin
                tx_rqst_d = 1'b1;
                tx_data_d = cmd_q;
                state_d   = S_WAIT_TX;
            end

            S_WAIT_TX: begin
                if (rx_ok) begin
                    state_d = S_WAIT_ACK;
                end else if (rx_bad || timer_q >= RESP_LAST) begin
                    state_d = S_RETRY;
                end
            end

            S_WAIT_ACK: begin
                if (valid) begin
                    if (rx_ok && rx_data == RSP_ACK) begin
                        state_d = (cmd_q == CMD_RESET) ? S_WAIT_BAT : S_READY;
                    end else if (rx_ok && rx_data == RSP_RESEND) begin
                        // A resend skips the inhibit window but still spends budget.
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_SEND;
                        end
                    end else begin
                        state_d = S_RETRY;
                    end
                end else if (timer_q >= RESP_LAST) begin
                    state_d = S_RETRY;
                end
            end

            S_WAIT_BAT: begin
                if (rx_ok && rx_data == RSP_BAT_OK) begin
                    state_d = S_SEND;
                    cmd_d   = CMD_ENABLE;
                end else if (rx_bad || (valid && rx_data == RSP_BAT_KO)) begin
                    state_d = S_RETRY;
                end else if (!valid && timer_q >= BAT_LAST) begin
                    state_d = S_RETRY;
                end
            end

            S_RETRY: begin
                if (retry_q == RETRY_MAX) begin
                    state_d = S_FAIL;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_INHIBIT;
                end
            end

            S_READY: begin
                if (start) begin
                    state_d = S_INHIBIT;
                    retry_d = '0;
                end else if (rx_ok) begin
                    code_d       = rx_data;
                    code_valid_d = 1'b1;
                end else if (rx_bad) begin
                    rx_err_d = 1'b1;
                end
            end

            S_FAIL: begin
                if (start) begin
                    state_d = S_INHIBIT;
                    retry_d = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Timer restarts on every state change and saturates instead of wrapping.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        en_d    = (state_d == S_SEND)     || (state_d == S_WAIT_TX) ||
                  (state_d == S_WAIT_ACK) || (state_d == S_WAIT_BAT) ||
                  (state_d == S_READY);
        ready_d = (state_d == S_READY);
        fail_d  = (state_d == S_FAIL);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_q        <= CMD_RESET;
            retry_q      <= '0;
            timer_q      <= '0;
            en_q         <= 1'b0;
            tx_rqst_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            en_q         <= en_d;
            tx_rqst_q    <= tx_rqst_d;
            tx_data_q    <= tx_data_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            rx_err_q     <= rx_err_d;
        end
    end

    assign en         = en_q;
    assign tx_rqst    = tx_rqst_q;
    assign tx_data    = tx_data_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign rx_err     = rx_err_q;

endmodule

// File: tb/tb_ps2_init_sequencer.sv
// Scoreboard bench for ps2_init_sequencer: stimulus pushes expected tx/code/rx_err events,
// a negedge monitor pops and compares them; level outputs are checked inline.

module tb_ps2_init_sequencer;
    import ps2_pkg::*;

    localparam int CLK_HZ      = 100_000;
    localparam int INHIBIT_US  = 150;
    localparam int RESP_TO_MS  = 2;
    localparam int BAT_TO_MS   = 5;
    localparam int MAX_RETRY   = 3;
    localparam int INHIBIT_CYC = 15;   // 150 us at 100 kHz
    localparam int BAT_CYC     = 500;  // 5 ms at 100 kHz
    localparam int LIMIT       = 2000;

    localparam logic [7:0] EV_TX    = 8'd1;
    localparam logic [7:0] EV_CODE  = 8'd2;
    localparam logic [7:0] EV_RXERR = 8'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       en;
    logic       tx_rqst;
    logic [7:0] tx_data;
    logic       valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    flags_t     flags = '0;
    logic       ready;
    logic       fail;
    logic [7:0] code;
    logic       code_valid;
    logic       rx_err;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    ps2_init_sequencer #(
        .CLK_HZ    (CLK_HZ),
        .INHIBIT_US(INHIBIT_US),
        .RESP_TO_MS(RESP_TO_MS),
        .BAT_TO_MS (BAT_TO_MS),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .en        (en),
        .tx_rqst   (tx_rqst),
        .tx_data   (tx_data),
        .valid     (valid),
        .rx_data   (rx_data),
        .flags     (flags),
        .ready     (ready),
        .fail      (fail),
        .code      (code),
        .code_valid(code_valid),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_event(input logic [7:0] kind, input logic [7:0] data);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected output event", {16'h0, kind, data}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("output event", {16'h0, kind, data}, {16'h0, e});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_rqst)    mon_event(EV_TX, tx_data);
            if (code_valid) mon_event(EV_CODE, code);
            if (rx_err)     mon_event(EV_RXERR, 8'h00);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_valid(input logic [7:0] data, input logic perr);
        @(posedge clk); #1;
        valid = 1'b1;
        rx_data = data;
        flags = '0;
        flags.parity_err = perr;
        @(posedge clk); #1;
        valid = 1'b0;
        flags = '0;
    endtask

    // Expects a command; returns at the negedge where tx_rqst is seen.
    task automatic expect_tx(input logic [7:0] cmd);
        int n = 0;
        exp_q.push_back({EV_TX, cmd});
        do begin
            @(negedge clk);
            n++;
        end while (!tx_rqst && n < LIMIT);
        if (!tx_rqst) check("tx_rqst wait expired", 32'd0, 32'd1);
    endtask

    // Counts negedges with en low, after first waiting for en to fall.
    task automatic measure_low(output int n);
        int guard = 0;
        n = 0;
        @(negedge clk);
        while (en && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        while (!en && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic reach_ready_from_reset_cmd();
        expect_tx(8'hFF);
        pulse_valid(8'h00, 1'b0);
        pulse_valid(8'hFA, 1'b0);
        pulse_valid(8'hAA, 1'b0);
        expect_tx(8'hF4);
        pulse_valid(8'h00, 1'b0);
        pulse_valid(8'hFA, 1'b0);
    endtask

    initial begin
        int n;
        logic [7:0] codes [3];
        codes[0] = 8'h1C; codes[1] = 8'hF0; codes[2] = 8'h1C;

        // Reset values
        #3;
        check("reset en", {31'd0, en}, 32'd0);
        check("reset tx_rqst/tx_data", {23'd0, tx_rqst, tx_data}, 32'd0);
        check("reset ready/fail", {30'd0, ready, fail}, 32'd0);
        check("reset code", {21'd0, code_valid, rx_err, code}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: full init sequence
        pulse_start();
        measure_low(n);
        check("first inhibit length", n, INHIBIT_CYC);
        reach_ready_from_reset_cmd();
        @(negedge clk);
        check("t1 ready", {30'd0, ready, fail}, 32'd2);
        check("t1 en", {31'd0, en}, 32'd1);

        // 2: forwarding in READY, plus a dropped byte
        foreach (codes[i]) begin
            exp_q.push_back({EV_CODE, codes[i]});
            pulse_valid(codes[i], 1'b0);
        end
        exp_q.push_back({EV_RXERR, 8'h00});
        pulse_valid(8'h55, 1'b1);
        repeat (2) @(negedge clk);
        check("code held after rx_err", {24'd0, code}, 32'h1C);
        check("ready after rx_err", {31'd0, ready}, 32'd1);

        // 3: restart from READY, resend once
        pulse_start();
        @(negedge clk);
        check("t3 ready/en drop", {30'd0, ready, en}, 32'd0);
        measure_low(n);
        check("t3 inhibit length", n, INHIBIT_CYC - 1);
        expect_tx(8'hFF);
        pulse_valid(8'h00, 1'b0);
        pulse_valid(8'hFE, 1'b0);
        @(negedge clk);
        check("t3 en kept on resend", {31'd0, en}, 32'd1);
        reach_ready_from_reset_cmd();
        @(negedge clk);
        check("t3 ready", {30'd0, ready, fail}, 32'd2);

        // 4: parity error on every ACK -> four windows then FAIL
        pulse_start();
        for (int w = 0; w < 4; w++) begin
            measure_low(n);
            check("t4 inhibit >= min", {31'd0, n >= INHIBIT_CYC - 1}, 32'd1);
            expect_tx(8'hFF);
            pulse_valid(8'h00, 1'b0);
            pulse_valid(8'hFA, 1'b1);
        end
        repeat (40) @(negedge clk);
        check("t4 fail", {29'd0, fail, ready, en}, 32'd4);

        // 5: restart from FAIL; silent BAT times out, then BAT=0xFC
        pulse_start();
        @(negedge clk);
        check("t4 fail cleared", {31'd0, fail}, 32'd0);
        measure_low(n);
        expect_tx(8'hFF);
        pulse_valid(8'h00, 1'b0);
        pulse_valid(8'hFA, 1'b0);
        n = 0;
        @(negedge clk);
        while (en && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        check("t5 bat timeout length", n, BAT_CYC);
        measure_low(n);
        check("t5 inhibit after timeout", {31'd0, n >= INHIBIT_CYC - 1}, 32'd1);
        expect_tx(8'hFF);
        pulse_valid(8'h00, 1'b0);
        pulse_valid(8'hFA, 1'b0);
        pulse_valid(8'h55, 1'b0);
        @(negedge clk);
        check("t5 other byte ignored", {31'd0, en}, 32'd1);
        pulse_valid(8'hFC, 1'b0);
        @(negedge clk);
        check("t5 FC -> retry", {31'd0, en}, 32'd0);
        measure_low(n);
        expect_tx(8'hFF);
        pulse_valid(8'h00, 1'b0);
        pulse_valid(8'hFA, 1'b0);

        // 6: asynchronous reset in WAIT_BAT
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async reset levels", {28'd0, en, ready, fail, tx_rqst}, 32'd0);
        check("t6 async reset data", {22'd0, code_valid, rx_err, tx_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_valid(8'hFA, 1'b0);
        repeat (60) @(negedge clk);
        check("t6 idle after reset", {29'd0, en, ready, fail}, 32'd0);
        pulse_start();
        measure_low(n);
        check("t6 restart inhibit", n, INHIBIT_CYC);
        expect_tx(8'hFF);
        repeat (3) @(negedge clk);

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
